// File: rtl/nonce_sweeper.sv
// Nonce sweep controller for the Hash2 double-SHA-256 core: issues one header per nonce,
// compares each digest against the target and stops on the first hit or at the end of the range.
module nonce_sweeper #(
    parameter int NONCE_W = 32,
    parameter int HDR_W   = 640,
    parameter int DIG_W   = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [HDR_W-1:0]   header_in,
    input  logic [DIG_W-1:0]   target,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    output logic [HDR_W-1:0]   hash_header,
    output logic               hash_start,
    input  logic               hash_done,
    input  logic [DIG_W-1:0]   hash_digest,
    output logic               busy,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic               exhausted,
    output logic [31:0]        hashes_done
);

    // state | meaning
    // IDLE  | no sweep since reset or abort
    // ISSUE | hash_start pulse for the current nonce
    // WAIT  | waiting for hash_done from the core
    // CHECK | compare registered digest against target, advance nonce
    // DONE  | sweep finished, results held until next start
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;

    state_t state, next_state;

    logic [HDR_W-NONCE_W-1:0] hdr;
    logic [DIG_W-1:0]         tgt;
    logic [DIG_W-1:0]         digest;
    logic [DIG_W-1:0]         value;
    logic [NONCE_W-1:0]       nonce;
    logic [NONCE_W-1:0]       nonce_last;
    logic                     load;
    logic                     hit;
    logic                     last;

    // Digest arrives in serialized byte order; the comparison needs it as a big-endian integer.
    always_comb begin
        value = '0;
        for (int b = 0; b < DIG_W / 8; b++) begin
            value[8*b +: 8] = digest[DIG_W-8-8*b +: 8];
        end
    end

    assign hit  = (value <= tgt);
    assign last = (nonce == nonce_last);
    assign load = ((state == IDLE) || (state == DONE)) && start && !abort;

    assign busy        = (state == ISSUE) || (state == WAIT) || (state == CHECK);
    assign hash_start  = (state == ISSUE);
    assign hash_header = {hdr, nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (load) next_state = ISSUE;
            ISSUE:      next_state = abort ? IDLE : WAIT;
            WAIT: begin
                if (abort)          next_state = IDLE;
                else if (hash_done) next_state = CHECK;
            end
            CHECK: begin
                if (abort)          next_state = IDLE;
                else if (hit||last) next_state = DONE;
                else                next_state = ISSUE;
            end
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr         <= '0;
            tgt         <= '0;
            digest      <= '0;
            nonce       <= '0;
            nonce_last  <= '0;
            found       <= 1'b0;
            found_nonce <= '0;
            exhausted   <= 1'b0;
            hashes_done <= '0;
        end else begin
            if (load) begin
                hdr         <= header_in[HDR_W-1:NONCE_W];
                tgt         <= target;
                nonce       <= nonce_start;
                nonce_last  <= nonce_end;
                found       <= 1'b0;
                exhausted   <= 1'b0;
                hashes_done <= '0;
            end
            if ((state == WAIT) && hash_done && !abort) begin
                digest <= hash_digest;
            end
            if ((state == CHECK) && !abort) begin
                if (hashes_done != 32'hFFFF_FFFF) hashes_done <= hashes_done + 32'd1;
                if (hit) begin
                    found       <= 1'b1;
                    found_nonce <= nonce;
                end else if (last) begin
                    exhausted <= 1'b1;
                end else begin
                    nonce <= nonce + {{(NONCE_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule
